matrix_operand_loader: RTL and testbench

Streams operand elements in over a valid/ready interface, assembles the two 2x2 operand matrices into the flat A/B vectors consumed by the systolic matrix multiplier, and launches each computation. It is the producer side of the multiplier's A/B operand interface. It holds the operands stable for the multiplier's fixed run length and blocks new input until the run finishes.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/matrix_operand_loader_if.sv | 34 +++
 rtl/matrix_operand_loader.sv | 121 ++++++++++++
 tb/tb_matrix_operand_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared types and constants for the matrix operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  // Loader sequencing: collect a frame, launch the multiplier, wait it out.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // A frame carries two 2x2 matrices back to back.
  localparam int FRAME_ELEMS = 8;
  localparam int MAT_ELEMS   = 4;

endpackage
`default_nettype wire

// File: rtl/matrix_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_operand_loader_if
// Description : Element stream in, flat A/B operands and launch/status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_operand_loader_if #(
  parameter int OP_WIDTH = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   in_data;
  logic                  in_last;
  logic [4*OP_WIDTH-1:0] mm_A;
  logic [4*OP_WIDTH-1:0] mm_B;
  logic                  mm_start;
  logic                  busy;
  logic                  err;

  // Element source / observer of the loader outputs.
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mm_A, mm_B, mm_start, busy, err
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mm_A, mm_B, mm_start, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_operand_loader
// Description : Assembles 8-element frames into 2x2 A/B operand matrices,
//               pulses mm_start and holds operands for the multiplier run.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_operand_loader
  import tpu_pkg::*;
#(
  parameter int OP_WIDTH    = 8,
  parameter int HOLD_CYCLES = 6
) (
  input  wire logic               clk,
  input  wire logic               reset,
  matrix_operand_loader_if.slave  bus
);

  localparam int              CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [2:0]      LAST_IDX = 3'(FRAME_ELEMS - 1);

  // The multiplier needs at least 6 cycles from its reset to a result.
  if (HOLD_CYCLES < 6) begin : g_hold_too_short
    $error("HOLD_CYCLES must be at least 6");
  end

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [4*OP_WIDTH-1:0] mm_a_q, mm_a_d;
  logic [4*OP_WIDTH-1:0] mm_b_q, mm_b_d;
  logic                  mm_start_q, mm_start_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  // Only LOAD accepts beats; decoded straight from the state register.
  assign bus.in_ready = (state_q == LOAD);
  assign bus.mm_A     = mm_a_q;
  assign bus.mm_B     = mm_b_q;
  assign bus.mm_start = mm_start_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

  // Next-state, element write-back, framing checks and hold countdown.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    err_d      = err_q;

    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          // idx[2] selects the matrix, idx[1:0] the row-major element.
          for (int k = 0; k < MAT_ELEMS; k++) begin
            if (int'(idx_q[1:0]) == k) begin
              if (!idx_q[2]) mm_a_d[k*OP_WIDTH +: OP_WIDTH] = bus.in_data;
              else           mm_b_d[k*OP_WIDTH +: OP_WIDTH] = bus.in_data;
            end
          end
          if ((idx_q == LAST_IDX) && bus.in_last) begin
            state_d = START;
            idx_d   = 3'd0;
          end else if ((idx_q == LAST_IDX) || bus.in_last) begin
            // Misframed: keep what was written, resynchronise at A11.
            err_d = 1'b1;
            idx_d = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      START: begin
        state_d    = HOLD;
        hold_cnt_d = CNT_W'(HOLD_CYCLES);
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - CNT_W'(1);
        if (hold_cnt_q == CNT_W'(1)) begin
          state_d = LOAD;
          idx_d   = 3'd0;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = 3'd0;
      end
    endcase

    // Registered status follows the state being entered.
    mm_start_d = (state_d == START);
    busy_d     = (state_d != LOAD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      idx_q      <= 3'd0;
      hold_cnt_q <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_start_q <= mm_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_operand_loader
// Description : Self-checking bench for matrix_operand_loader with a
//               frame/timeline reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_operand_loader;
  import tpu_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic clk;
  logic reset;

  matrix_operand_loader_if #(.OP_WIDTH(W)) bus();

  matrix_operand_loader #(.OP_WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: frame position, stored elements, sticky error and the
  // clock edge at which the last launch happened (L).
  int         ncyc     = 0;
  int         k        = 0;
  int         L        = -1000;
  int         acc_cnt  = 0;
  int         last_acc = -1;
  logic [W-1:0] ma [4];
  logic [W-1:0] mb [4];
  logic       merr     = 1'b0;
  int         start_cnt = 0;
  int         stall_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Launch at edge L keeps the loader busy for observation slots L..L+H.
  function automatic logic model_busy(input int n);
    return (n >= L) && (n <= L + H);
  endfunction

  function automatic logic [4*W-1:0] pack(input logic [W-1:0] m [4]);
    return {m[3], m[2], m[1], m[0]};
  endfunction

  // Model update on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      ncyc++;
      if (reset) begin
        k = 0; merr = 1'b0; L = -1000;
        for (int i = 0; i < 4; i++) begin ma[i] = '0; mb[i] = '0; end
      end else if (bus.in_valid && !model_busy(ncyc - 1)) begin
        acc_cnt++;
        last_acc = ncyc;
        if (k < 4) ma[k] = bus.in_data; else mb[k-4] = bus.in_data;
        if (k == FRAME_ELEMS - 1 && bus.in_last) begin
          L = ncyc; k = 0;
        end else if (k == FRAME_ELEMS - 1 || bus.in_last) begin
          merr = 1'b1; k = 0;
        end else begin
          k++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (ncyc > 0) begin
        chk("in_ready", 64'(bus.in_ready), 64'(!model_busy(ncyc)));
        chk("mm_start", 64'(bus.mm_start), 64'(ncyc == L));
        chk("busy",     64'(bus.busy),     64'(model_busy(ncyc)));
        chk("err",      64'(bus.err),      64'(merr));
        chk("mm_A",     64'(bus.mm_A),     64'(pack(ma)));
        chk("mm_B",     64'(bus.mm_B),     64'(pack(mb)));
        if (bus.mm_start === 1'b1) start_cnt++;
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b0) stall_cnt++;
      end
    end
  end

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Present one beat and wait (bounded) for it to be taken.
  task automatic send_beat(input logic [W-1:0] d, input logic last, input bit bubble);
    int n0;
    bit ok;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    n0 = acc_cnt;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != n0) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL beat_accept: got=no handshake expected=handshake within 40 cycles");
    end
    if (bubble) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int base, input bit bubble, input bit with_last);
    for (int i = 0; i < FRAME_ELEMS; i++)
      send_beat(W'(base + i), with_last && (i == FRAME_ELEMS - 1),
                bubble && (i < FRAME_ELEMS - 1));
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 30) begin
      n++; @(posedge clk); #1;
    end
    if (bus.in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s_ready_timeout: got=%0b expected=1", nm, bus.in_ready);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // C = A x B from the presented operands, against hand-computed results.
  task automatic chk_product(input string nm, input int e0, input int e1, input int e2, input int e3);
    int a [4];
    int b [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = int'(bus.mm_A[i*W +: W]);
      b[i] = int'(bus.mm_B[i*W +: W]);
    end
    chk({nm, "_C11"}, 64'(a[0]*b[0] + a[1]*b[2]), 64'(e0));
    chk({nm, "_C12"}, 64'(a[0]*b[1] + a[1]*b[3]), 64'(e1));
    chk({nm, "_C21"}, 64'(a[2]*b[0] + a[3]*b[2]), 64'(e2));
    chk({nm, "_C22"}, 64'(a[2]*b[1] + a[3]*b[3]), 64'(e3));
  endtask

  initial begin : main
    int s0, st0, lt, n;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_A",     64'(bus.mm_A),     64'd0);
    chk("rst_B",     64'(bus.mm_B),     64'd0);
    chk("rst_start", 64'(bus.mm_start), 64'd0);
    chk("rst_busy",  64'(bus.busy),     64'd0);
    chk("rst_err",   64'(bus.err),      64'd0);

    // Clean frame 1..8
    s0 = start_cnt;
    send_frame(1, 1'b0, 1'b1);
    idle();
    chk("clean_A",       64'(bus.mm_A),  64'h04030201);
    chk("clean_B",       64'(bus.mm_B),  64'h08070605);
    chk("clean_start",   64'(bus.mm_start), 64'd1);
    chk("clean_model_A", 64'(pack(ma)), 64'h04030201);
    chk_product("clean", 19, 22, 43, 50);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      n++; @(posedge clk); #1;
    end
    chk("clean_ready_low_cycles", 64'(n), 64'd7);
    chk("clean_start_count", 64'(start_cnt - s0), 64'd1);

    // Bubbled frame after a fresh reset
    do_reset(2);
    s0 = start_cnt;
    send_frame(1, 1'b1, 1'b1);
    idle();
    chk("bubble_A",     64'(bus.mm_A),     64'h04030201);
    chk("bubble_B",     64'(bus.mm_B),     64'h08070605);
    chk("bubble_start", 64'(bus.mm_start), 64'd1);
    wait_ready("bubble");
    chk("bubble_start_count", 64'(start_cnt - s0), 64'd1);

    // Early in_last on beat 3
    s0 = start_cnt;
    send_beat(8'h31, 1'b0, 1'b0);
    send_beat(8'h32, 1'b0, 1'b0);
    send_beat(8'h33, 1'b1, 1'b0);
    idle();
    chk("early_err",   64'(bus.err),      64'd1);
    chk("early_A",     64'(bus.mm_A),     64'h04333231);
    repeat (3) @(posedge clk);
    #1;
    chk("early_ready", 64'(bus.in_ready), 64'd1);
    chk("early_no_start", 64'(start_cnt - s0), 64'd0);
    send_frame(9, 1'b0, 1'b1);
    idle();
    chk("early_next_A",   64'(bus.mm_A), 64'h0C0B0A09);
    chk("early_next_B",   64'(bus.mm_B), 64'h100F0E0D);
    chk("early_err_held", 64'(bus.err),  64'd1);
    chk_product("early_next", 267, 286, 323, 346);
    wait_ready("early_next");
    chk("early_next_start_count", 64'(start_cnt - s0), 64'd1);

    // Missing in_last on beat 8
    do_reset(2);
    s0 = start_cnt;
    send_frame(1, 1'b0, 1'b0);
    idle();
    chk("nolast_err",   64'(bus.err),      64'd1);
    chk("nolast_ready", 64'(bus.in_ready), 64'd1);
    send_beat(8'h55, 1'b0, 1'b0);
    idle();
    chk("nolast_wrap_A", 64'(bus.mm_A), 64'h04030255);
    chk("nolast_no_start", 64'(start_cnt - s0), 64'd0);

    // Reset after 5 beats, then a clean frame
    for (int i = 0; i < 5; i++) send_beat(W'(i + 1), 1'b0, 1'b0);
    idle();
    do_reset(1);
    chk("midrst_A",     64'(bus.mm_A),     64'd0);
    chk("midrst_B",     64'(bus.mm_B),     64'd0);
    chk("midrst_err",   64'(bus.err),      64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_busy",  64'(bus.busy),     64'd0);
    send_frame(1, 1'b0, 1'b1);
    idle();
    chk("midrst_clean_A", 64'(bus.mm_A), 64'h04030201);
    chk("midrst_clean_B", 64'(bus.mm_B), 64'h08070605);
    chk_product("midrst", 19, 22, 43, 50);
    wait_ready("midrst");

    // Back-to-back with the next frame queued during HOLD
    st0 = stall_cnt;
    send_frame(1, 1'b0, 1'b1);
    lt = L;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h21;
    bus.in_last  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_B_stable_t7", 64'(bus.mm_B),     64'h08070605);
    chk("b2b_ready_t7",    64'(bus.in_ready), 64'd0);
    send_beat(8'h21, 1'b0, 1'b0);
    chk("b2b_first_beat_offset", 64'(last_acc - lt), 64'd8);
    chk("b2b_stall_cycles", 64'(stall_cnt - st0), 64'd7);
    for (int i = 1; i < FRAME_ELEMS; i++)
      send_beat(W'(8'h21 + i), i == FRAME_ELEMS - 1, 1'b0);
    idle();
    chk("b2b_A", 64'(bus.mm_A), 64'h24232221);
    chk("b2b_B", 64'(bus.mm_B), 64'h28272625);

    // Reset in the middle of HOLD aborts it at once
    repeat (2) @(posedge clk);
    #1;
    do_reset(1);
    chk("holdrst_ready", 64'(bus.in_ready), 64'd1);
    chk("holdrst_busy",  64'(bus.busy),     64'd0);
    chk("holdrst_A",     64'(bus.mm_A),     64'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
